// File: rtl/commit_pkg.sv
// Shared types and constants for the retirement monitor.
package commit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    HANG = 2'd3
  } run_state_e;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_RUN  = 32'd1;
  localparam logic [31:0] ST_HALT = 32'd2;
  localparam logic [31:0] ST_HANG = 32'd3;

  localparam logic [31:0] EBREAK_INST_DEF = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_info_t;

  // Map the internal FSM encoding onto the 32-bit word the DPI side expects.
  function automatic logic [31:0] to_state_word(input run_state_e s);
    logic [31:0] w;
    case (s)
      IDLE:    w = ST_IDLE;
      RUN:     w = ST_RUN;
      HALT:    w = ST_HALT;
      default: w = ST_HANG;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// WB-stage retirement bus in, registered commit record out.
interface commit_monitor_if;
  logic        wb_valid;
  logic        wb_stall;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_rd_wen;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic [31:0] gpr_a0;

  logic        wb_commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_wen;
  logic [31:0] commit_waddr;
  logic [31:0] commit_wdata;

  modport master (
    output wb_valid, wb_stall, wb_pc, wb_inst, wb_rd_wen, wb_rd_addr, wb_rd_data, gpr_a0,
    input  wb_commit, commit_pc, commit_inst, commit_wen, commit_waddr, commit_wdata
  );

  modport slave (
    input  wb_valid, wb_stall, wb_pc, wb_inst, wb_rd_wen, wb_rd_addr, wb_rd_data, gpr_a0,
    output wb_commit, commit_pc, commit_inst, commit_wen, commit_waddr, commit_wdata
  );
endinterface

// File: rtl/commit_trace_ring.sv
// Ring of the most recently retired PCs, read newest-first by index.
module commit_trace_ring #(
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [31:0]                    wr_pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [31:0]                    rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]   cnt
);

  localparam int unsigned IW = $clog2(TRACE_DEPTH);

  logic [31:0]   mem [TRACE_DEPTH];
  logic [IW-1:0] wp;
  logic [IW-1:0] rd_ptr;

  // Write pointer, saturating fill count and ring storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wp] <= wr_pc;
      wp      <= wp + IW'(1);
      if (cnt != (IW+1)'(TRACE_DEPTH)) cnt <= cnt + (IW+1)'(1);
    end
  end

  // Index 0 is the last entry written; unfilled slots read as zero.
  always_comb begin
    rd_ptr = wp - IW'(1) - rd_idx;
    rd_pc  = ((IW+1)'(rd_idx) < cnt) ? mem[rd_ptr] : 32'd0;
  end

endmodule

// File: rtl/commit_monitor.sv
// Retirement tracker: commit pulse, counters, trace ring, halt and hang detection.
module commit_monitor
  import commit_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [31:0] EBREAK_INST = EBREAK_INST_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  commit_monitor_if.slave                bus,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [63:0]                    instret,
  output logic [63:0]                    cycles,
  output logic [31:0]                    state,
  output logic [31:0]                    halt_code,
  output logic [31:0]                    trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
);

  localparam int unsigned WW = $clog2(TIMEOUT);

  run_state_e   state_q, state_d;
  logic [WW-1:0] wd_q;
  commit_info_t info_q;
  logic         commit_q;
  logic         active;
  logic         ret;
  logic         is_ebreak;
  logic         expire;

  // Retirement qualification and watchdog expiry; a retirement always beats expiry.
  always_comb begin
    active    = (state_q == IDLE) || (state_q == RUN);
    ret       = bus.wb_valid && !bus.wb_stall && active;
    is_ebreak = (bus.wb_inst == EBREAK_INST);
    expire    = active && !ret && (wd_q == WW'(TIMEOUT - 1));
  end

  // Run-state next-state logic; HALT and HANG only leave through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (ret && is_ebreak) state_d = HALT;
        else if (ret)         state_d = RUN;
        else if (expire)      state_d = HANG;
      end
      default: state_d = state_q;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Commit record, counters, halt code and watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_q  <= 1'b0;
      info_q    <= '0;
      instret   <= '0;
      cycles    <= '0;
      halt_code <= '0;
      wd_q      <= '0;
    end else begin
      commit_q <= ret;
      if (active) cycles <= cycles + 64'd1;
      if (ret) begin
        info_q.pc    <= bus.wb_pc;
        info_q.inst  <= bus.wb_inst;
        info_q.wen   <= bus.wb_rd_wen && (bus.wb_rd_addr != 5'd0);
        info_q.waddr <= bus.wb_rd_addr;
        info_q.wdata <= bus.wb_rd_data;
        instret      <= instret + 64'd1;
        wd_q         <= '0;
        if (is_ebreak) halt_code <= bus.gpr_a0;
      end else if (active && !expire) begin
        wd_q <= wd_q + WW'(1);
      end
    end
  end

  assign bus.wb_commit    = commit_q;
  assign bus.commit_pc    = info_q.pc;
  assign bus.commit_inst  = info_q.inst;
  assign bus.commit_wen   = info_q.wen;
  assign bus.commit_waddr = 32'(info_q.waddr);
  assign bus.commit_wdata = info_q.wdata;
  assign state            = to_state_word(state_q);

  commit_trace_ring #(.TRACE_DEPTH(TRACE_DEPTH)) u_ring (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (ret),
    .wr_pc  (bus.wb_pc),
    .rd_idx (trace_idx),
    .rd_pc  (trace_pc),
    .cnt    (trace_cnt)
  );

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor with a short watchdog timeout.
module tb_commit_monitor;
  import commit_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  logic        clock;
  logic        reset;
  logic [3:0]  trace_idx;
  logic [63:0] instret;
  logic [63:0] cycles;
  logic [31:0] state;
  logic [31:0] halt_code;
  logic [31:0] trace_pc;
  logic [4:0]  trace_cnt;

  int tests;
  int errors;

  commit_monitor_if bus ();

  commit_monitor #(.TRACE_DEPTH(DEPTH), .TIMEOUT(TMO), .EBREAK_INST(EBRK)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .trace_idx (trace_idx),
    .instret   (instret),
    .cycles    (cycles),
    .state     (state),
    .halt_code (halt_code),
    .trace_pc  (trace_pc),
    .trace_cnt (trace_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic [31:0] inst);
    bus.wb_valid = v;
    bus.wb_stall = s;
    bus.wb_pc    = pc;
    bus.wb_inst  = inst;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_commit"}, 64'(bus.wb_commit), 64'd0);
    chk({tag, "_instret"}, instret, 64'd0);
    chk({tag, "_cycles"}, cycles, 64'd0);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_halt"}, 64'(halt_code), 64'd0);
    chk({tag, "_tcnt"}, 64'(trace_cnt), 64'd0);
    chk({tag, "_tpc"}, 64'(trace_pc), 64'd0);
    chk({tag, "_cpc"}, 64'(bus.commit_pc), 64'd0);
    chk({tag, "_cwdata"}, 64'(bus.commit_wdata), 64'd0);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    reset = 1'b1;
    trace_idx = '0;
    drive(1'b0, 1'b0, 32'd0, NOP);
    bus.wb_rd_wen = 1'b0;
    bus.wb_rd_addr = '0;
    bus.wb_rd_data = '0;
    bus.gpr_a0 = '0;
    tick();
    tick();
    check_reset_state("rst");

    // Three back-to-back retirements.
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h8000_0000, NOP);
    tick();
    chk("b2b_c1", 64'(bus.wb_commit), 64'd1);
    chk("b2b_pc1", 64'(bus.commit_pc), 64'h8000_0000);
    drive(1'b1, 1'b0, 32'h8000_0004, NOP);
    tick();
    chk("b2b_c2", 64'(bus.wb_commit), 64'd1);
    drive(1'b1, 1'b0, 32'h8000_0008, NOP);
    tick();
    chk("b2b_c3", 64'(bus.wb_commit), 64'd1);
    chk("b2b_instret", instret, 64'd3);
    chk("b2b_state", 64'(state), 64'd1);
    chk("b2b_tpc0", 64'(trace_pc), 64'h8000_0008);
    chk("b2b_tcnt", 64'(trace_cnt), 64'd3);
    chk("b2b_cycles", cycles, 64'd3);
    drive(1'b0, 1'b0, 32'h8000_000C, NOP);
    tick();
    chk("idle_commit", 64'(bus.wb_commit), 64'd0);
    chk("hold_pc", 64'(bus.commit_pc), 64'h8000_0008);
    trace_idx = 4'd2;
    #1;
    chk("tpc_idx2", 64'(trace_pc), 64'h8000_0000);
    trace_idx = 4'd3;
    #1;
    chk("tpc_unfilled", 64'(trace_pc), 64'd0);
    trace_idx = 4'd0;

    // rd write qualification.
    drive(1'b1, 1'b0, 32'h8000_0010, NOP);
    bus.wb_rd_wen = 1'b1;
    bus.wb_rd_addr = 5'd0;
    bus.wb_rd_data = 32'h0000_DEAD;
    tick();
    chk("x0_wen", 64'(bus.commit_wen), 64'd0);
    chk("x0_waddr", 64'(bus.commit_waddr), 64'd0);
    chk("x0_wdata", 64'(bus.commit_wdata), 64'h0000_DEAD);
    drive(1'b1, 1'b0, 32'h8000_0014, NOP);
    bus.wb_rd_addr = 5'd5;
    bus.wb_rd_data = 32'h0000_1234;
    tick();
    chk("x5_wen", 64'(bus.commit_wen), 64'd1);
    chk("x5_waddr", 64'(bus.commit_waddr), 64'd5);
    chk("x5_wdata", 64'(bus.commit_wdata), 64'h0000_1234);
    chk("x5_instret", instret, 64'd5);
    bus.wb_rd_wen = 1'b0;

    // Stalled WB retires exactly once when released.
    drive(1'b1, 1'b1, 32'h8000_0100, NOP);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_commit", 64'(bus.wb_commit), 64'd0);
    end
    chk("stall_instret", instret, 64'd5);
    drive(1'b1, 1'b0, 32'h8000_0100, NOP);
    tick();
    chk("unstall_commit", 64'(bus.wb_commit), 64'd1);
    drive(1'b0, 1'b0, 32'h8000_0104, NOP);
    tick();
    chk("unstall_once", 64'(bus.wb_commit), 64'd0);
    chk("unstall_instret", instret, 64'd6);
    chk("unstall_cycles", cycles, 64'd12);

    // ebreak halts and is itself committed.
    drive(1'b1, 1'b0, 32'h8000_0200, EBRK);
    bus.gpr_a0 = 32'd0;
    tick();
    chk("ebrk_commit", 64'(bus.wb_commit), 64'd1);
    chk("ebrk_inst", 64'(bus.commit_inst), 64'(EBRK));
    chk("ebrk_state", 64'(state), 64'd2);
    chk("ebrk_code", 64'(halt_code), 64'd0);
    chk("ebrk_instret", instret, 64'd7);
    chk("ebrk_cycles", cycles, 64'd13);
    drive(1'b1, 1'b0, 32'h8000_0204, NOP);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_commit", 64'(bus.wb_commit), 64'd0);
    end
    chk("halt_instret", instret, 64'd7);
    chk("halt_cycles", cycles, 64'd13);
    chk("halt_state", 64'(state), 64'd2);
    chk("halt_tcnt", 64'(trace_cnt), 64'd7);
    chk("halt_tpc0", 64'(trace_pc), 64'h8000_0200);

    // Reset out of HALT, then ebreak straight from IDLE with a nonzero a0.
    reset = 1'b1;
    tick();
    check_reset_state("rst_halt");
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h8000_0000, EBRK);
    bus.gpr_a0 = 32'h0000_002A;
    tick();
    chk("idle_ebrk_state", 64'(state), 64'd2);
    chk("idle_ebrk_code", 64'(halt_code), 64'h2A);
    chk("idle_ebrk_instret", instret, 64'd1);

    // Watchdog with no commits: HANG exactly TMO cycles after reset release.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, NOP);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("wd_pre_state", 64'(state), 64'd0);
    tick();
    chk("wd_hang_state", 64'(state), 64'd3);
    chk("wd_hang_cycles", cycles, 64'd8);
    drive(1'b1, 1'b0, 32'h8000_0000, NOP);
    tick();
    chk("hang_commit", 64'(bus.wb_commit), 64'd0);
    chk("hang_cycles", cycles, 64'd8);
    chk("hang_instret", instret, 64'd0);

    // Retirement on the expiry cycle wins and clears the watchdog.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, NOP);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    drive(1'b1, 1'b0, 32'h8000_0040, NOP);
    tick();
    chk("race_state", 64'(state), 64'd1);
    chk("race_commit", 64'(bus.wb_commit), 64'd1);
    drive(1'b0, 1'b0, 32'd0, NOP);
    for (int i = 0; i < 7; i++) tick();
    chk("race_wd_cleared", 64'(state), 64'd1);
    tick();
    chk("race_hang", 64'(state), 64'd3);

    // Ring wrap with 20 retirements.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), NOP);
      tick();
    end
    chk("ring_tcnt", 64'(trace_cnt), 64'd16);
    chk("ring_idx0", 64'(trace_pc), 64'h4C);
    trace_idx = 4'd15;
    #1;
    chk("ring_idx15", 64'(trace_pc), 64'h10);
    trace_idx = 4'd7;
    #1;
    chk("ring_idx7", 64'(trace_pc), 64'h30);
    chk("ring_instret", instret, 64'd20);
    trace_idx = 4'd0;

    // Mid-stream reset: no pulse on the reset edge, everything cleared.
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0050, NOP);
    tick();
    check_reset_state("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
Retirement tracker between the WB stage and the difftest DPI black box. Qualifies WB-stage retirements and registers them into a one-cycle wb_commit pulse with the committed pc/inst/rd write. Also maintains instret/cycle counters, a retired-PC trace ring, an ebreak halt detector and a no-commit watchdog. Publishes a 32-bit run state for the DPI `state` port.

Parameters:
TRACE_DEPTH, 16, retired-PC ring entries; must be a power of 2, at least 2.
TIMEOUT, 1024, consecutive cycles without a commit before HANG; at least 2.
EBREAK_INST, 32'h00100073, instruction word that ends simulation.

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
wb_valid  in  1  WB stage holds a valid instruction
wb_stall  in  1  WB stalled; no retirement this cycle
wb_pc  in  32  pc of WB instruction
wb_inst  in  32  instruction word in WB
wb_rd_wen  in  1  WB writes rd
wb_rd_addr  in  5  rd index
wb_rd_data  in  32  rd write value
gpr_a0  in  32  current architectural x10, used as the halt code
trace_idx  in  log2(TRACE_DEPTH)  trace read index; 0 = most recent commit
wb_commit  out  1  one-cycle pulse per retired instruction
commit_pc  out  32  pc of last commit
commit_inst  out  32  inst of last commit
commit_wen  out  1  last commit wrote a nonzero rd
commit_waddr  out  32  rd index, zero-extended
commit_wdata  out  32  rd value
instret  out  64  retired-instruction count
cycles  out  64  cycles spent in IDLE or RUN
state  out  32  run state, zero-extended: IDLE=0, RUN=1, HALT=2, HANG=3
halt_code  out  32  a0 captured at ebreak commit
trace_pc  out  32  ring entry selected by trace_idx (combinational read)
trace_cnt  out  log2(TRACE_DEPTH)+1  valid ring entries, saturates at TRACE_DEPTH

Behaviour:
- Reset: every output and register is 0; state=IDLE; ring pointer=0; watchdog=0.
- Retire condition: ret = wb_valid & ~wb_stall & (state==IDLE | state==RUN).
- Latency 1: commit_* and wb_commit are registered. wb_commit is high the cycle after ret and low otherwise.
- commit_* hold their last values when wb_commit=0.
- commit_wen = wb_rd_wen & (wb_rd_addr != 0). commit_wdata is captured regardless of commit_wen.
- instret increments by 1 per ret and wraps at 2^64.
- cycles increments every cycle in IDLE or RUN, freezes in HALT/HANG, and wraps at 2^64.
- FSM transitions:
  - IDLE -> RUN on first ret.
  - IDLE/RUN -> HALT on ret with wb_inst==EBREAK_INST; halt_code <= gpr_a0 on the same edge.
  - IDLE/RUN -> HANG when the watchdog reaches TIMEOUT-1 with no ret that cycle.
  - HALT and HANG are terminal until reset.
- Watchdog:
  - Clears on ret.
  - Otherwise increments in IDLE/RUN and holds in HALT/HANG.
  - With no commits after reset, HANG is entered exactly TIMEOUT cycles after reset deassertion.
- The ebreak itself is committed: wb_commit pulses, instret counts it, and the trace records it. A retirement arriving in HALT/HANG is ignored.
- Simultaneous ret and watchdog expiry: ret wins; the watchdog clears; no HANG.
- Trace ring:
  - On ret: mem[wp] <= wb_pc; wp <= wp+1 mod TRACE_DEPTH; trace_cnt++ saturating at TRACE_DEPTH.
  - trace_pc = mem[(wp-1-trace_idx) mod TRACE_DEPTH]; this reflects the write pointer after the last edge.
  - Entries with trace_idx >= trace_cnt return 0. Ring contents are cleared on reset.
- Reset mid-run, including from HALT/HANG: synchronous return to the reset state on the next edge. No wb_commit pulse occurs on that edge.
- Back-to-back ret on consecutive cycles gives a continuous-high wb_commit, one instruction per cycle.

Decomposition:
- Shared package commit_pkg holds:
  - the state encoding constants (IDLE/RUN/HALT/HANG, 32-bit);
  - EBREAK_INST default;
  - a commit_info struct {pc, inst, wen, waddr, wdata}.
- One sub-module, commit_trace_ring: parameterised by TRACE_DEPTH; contains the pointer, count and combinational indexed read.
- Counters, watchdog and FSM stay in commit_monitor.

Test Plan:
- Reset, then 3 consecutive rets with pc 0x80000000/04/08 -> wb_commit high for cycles 2-4; instret=3; state=RUN; trace_idx=0 gives 0x80000008; trace_cnt=3.
- ret with wb_rd_wen=1, rd_addr=0, data=0xDEAD -> commit_wen=0, commit_waddr=0; ret with rd_addr=5, data=0x1234 -> commit_wen=1, commit_wdata=0x1234.
- wb_valid=1, wb_stall=1 for 4 cycles, then stall released -> exactly one wb_commit pulse; instret +1.
- ebreak with gpr_a0=0 -> next cycle state=2, halt_code=0. Further wb_valid retirements -> no wb_commit, instret frozen, cycles frozen.
- TIMEOUT=8, no commits after reset -> state=3 exactly 8 cycles after reset release. Same setup with a ret on the expiry cycle -> state=1, watchdog cleared.
- TRACE_DEPTH=16, 20 rets with pc=4*i -> trace_cnt=16; idx 0 gives 0x4C; idx 15 gives 0x10. Assert reset mid-stream -> all outputs 0 on the next cycle.
